// File: rtl/data_mem_sys_pkg.sv
// Shared definitions for the data-side memory system: memory command codes
// issued by the MEM stage, address-region decode results, MMIO word offsets,
// TX_STAT bit positions and small helpers for command classification,
// alignment checking and store lane/data generation.
package data_mem_sys_pkg;

    // Memory command codes presented on MEM_mem_cmd.
    typedef enum logic [3:0] {
        MEM_NONE = 4'h0,
        MEM_LB   = 4'h1,
        MEM_LH   = 4'h2,
        MEM_LW   = 4'h3,
        MEM_LBU  = 4'h4,
        MEM_LHU  = 4'h5,
        MEM_SB   = 4'h6,
        MEM_SH   = 4'h7,
        MEM_SW   = 4'h8
    } mem_cmd_e;

    // Result of decoding a byte address.
    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_MMIO = 2'd1,
        REGION_NONE = 2'd2
    } region_e;

    // MMIO word offsets inside the 16-byte window (address bits [3:2]).
    localparam logic [1:0] MMIO_CNT_LO  = 2'd0;
    localparam logic [1:0] MMIO_CNT_HI  = 2'd1;
    localparam logic [1:0] MMIO_TX_DATA = 2'd2;
    localparam logic [1:0] MMIO_TX_STAT = 2'd3;

    // TX_STAT bit positions; bit 2 is reserved and reads zero.
    localparam int TXS_FULL_BIT  = 0;
    localparam int TXS_EMPTY_BIT = 1;
    localparam int TXS_OVF_BIT   = 3;
    localparam int TXS_COUNT_LSB = 4;

    function automatic logic cmd_is_load(input mem_cmd_e cmd);
        case (cmd)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: cmd_is_load = 1'b1;
            default:                                  cmd_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic cmd_is_store(input mem_cmd_e cmd);
        case (cmd)
            MEM_SB, MEM_SH, MEM_SW: cmd_is_store = 1'b1;
            default:                cmd_is_store = 1'b0;
        endcase
    endfunction

    // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
    function automatic logic cmd_misaligned(input mem_cmd_e cmd, input logic [1:0] lsb);
        case (cmd)
            MEM_LH, MEM_LHU, MEM_SH: cmd_misaligned = lsb[0];
            MEM_LW, MEM_SW:          cmd_misaligned = (lsb != 2'b00);
            default:                 cmd_misaligned = 1'b0;
        endcase
    endfunction

    // Byte-lane write enables for an aligned store.
    function automatic logic [3:0] store_lanes(input mem_cmd_e cmd, input logic [1:0] lsb);
        case (cmd)
            MEM_SB:  store_lanes = 4'b0001 << lsb;
            MEM_SH:  store_lanes = lsb[1] ? 4'b1100 : 4'b0011;
            MEM_SW:  store_lanes = 4'b1111;
            default: store_lanes = 4'b0000;
        endcase
    endfunction

    // Store data arrives unshifted; replicate it so every lane carries it.
    function automatic logic [31:0] store_data(input mem_cmd_e cmd, input logic [31:0] din);
        case (cmd)
            MEM_SB:  store_data = {4{din[7:0]}};
            MEM_SH:  store_data = {2{din[15:0]}};
            default: store_data = din;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_sys_tx_fifo.sv
// Byte FIFO feeding the TX valid/ready port.
// Ports: clk, rst (sync, active-high); push/din write side; pop read side
// (ignored while empty); dout shows the head straight from storage; full,
// empty, count (entries held) and a sticky ovf set when a push is dropped.
// A push and a pop in the same cycle both take effect, even when full.
module data_mem_sys_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});

    // A pop frees a slot this cycle, so a push while full still fits.
    assign pop_s  = pop && !empty_s;
    assign push_s = push && (!full_s || pop_s);
    assign drop_s = push && full_s && !pop_s;

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;
    assign ovf   = ovf_r;

endmodule

// File: rtl/data_mem_sys.sv
// Data-side memory system sitting after the processor MEM stage.
// Every access completes in its own cycle: reads are combinational, writes
// land on the next posedge. Address map: 16-byte MMIO window at MMIO_BASE
// (cycle counter low/high-snapshot, TX data, TX status), word RAM for
// addr[31:2] < DEPTH_WORDS, everything else unmapped (reads 0).
// RAM image loading is left to the harness (hierarchical preload of ram_r).
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   MEM_mem_addr/cmd   byte address and command from the MEM stage
//   MEM_mem_din        unshifted store data
//   DM_mem_dout        aligned word at MEM_mem_addr[31:2]
//   tx_data/valid/ready  TX byte stream, transfer when valid & ready
//   mem_err            sticky misaligned/unmapped access flag
module data_mem_sys
    import data_mem_sys_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          TX_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_mem_addr,
    input  logic [3:0]  MEM_mem_cmd,
    input  logic [31:0] MEM_mem_din,
    output logic [31:0] DM_mem_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_err
);
    localparam int RAM_AW = $clog2(DEPTH_WORDS);
    localparam int TX_CW  = $clog2(TX_DEPTH) + 1;

    mem_cmd_e          cmd_s;
    region_e           region_s;
    logic [1:0]        mmio_off_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              is_load_s;
    logic              is_store_s;
    logic              misaligned_s;
    logic              access_err_s;
    logic              ram_we_s;
    logic [3:0]        lanes_s;
    logic [31:0]       wdata_s;
    logic              snap_take_s;
    logic              tx_push_s;
    logic              tx_pop_s;
    logic              tx_full_s;
    logic              tx_empty_s;
    logic              tx_ovf_s;
    logic [TX_CW-1:0]  tx_count_s;
    logic [31:0]       tx_stat_s;
    logic [31:0]       dout_s;

    logic [31:0]       ram_r [DEPTH_WORDS];
    logic [63:0]       cnt_r;
    logic [31:0]       snap_r;
    logic              mem_err_r;

    assign cmd_s      = mem_cmd_e'(MEM_mem_cmd);
    assign mmio_off_s = MEM_mem_addr[3:2];
    assign ram_idx_s  = MEM_mem_addr[RAM_AW+1:2];

    // Address decode; the MMIO window is checked first.
    always_comb begin
        region_s = REGION_NONE;
        if (MEM_mem_addr[31:4] == MMIO_BASE[31:4]) begin
            region_s = REGION_MMIO;
        end else if ({2'b00, MEM_mem_addr[31:2]} < 32'(DEPTH_WORDS)) begin
            region_s = REGION_RAM;
        end else begin
            region_s = REGION_NONE;
        end
    end

    // Access classification and the write/push/snapshot strobes derived from it.
    always_comb begin
        is_load_s    = cmd_is_load(cmd_s);
        is_store_s   = cmd_is_store(cmd_s);
        misaligned_s = cmd_misaligned(cmd_s, MEM_mem_addr[1:0]);
        lanes_s      = store_lanes(cmd_s, MEM_mem_addr[1:0]);
        wdata_s      = store_data(cmd_s, MEM_mem_din);
        access_err_s = (is_load_s || is_store_s)
                       && (misaligned_s || (region_s == REGION_NONE));
        ram_we_s     = is_store_s && !misaligned_s && (region_s == REGION_RAM);
        // Misaligned stores to TX_DATA are errors, not pushes.
        tx_push_s    = is_store_s && !misaligned_s && (region_s == REGION_MMIO)
                       && (mmio_off_s == MMIO_TX_DATA);
        // Reading CNT_LO freezes the high word so a following CNT_HI read is coherent.
        snap_take_s  = is_load_s && (region_s == REGION_MMIO)
                       && (mmio_off_s == MMIO_CNT_LO);
    end

    // TX status word assembly.
    always_comb begin
        tx_stat_s                          = 32'h0000_0000;
        tx_stat_s[TXS_COUNT_LSB +: 4]      = 4'(tx_count_s);
        tx_stat_s[TXS_OVF_BIT]             = tx_ovf_s;
        tx_stat_s[TXS_EMPTY_BIT]           = tx_empty_s;
        tx_stat_s[TXS_FULL_BIT]            = tx_full_s;
    end

    // Combinational read data; returned for every command, including none.
    always_comb begin
        dout_s = 32'h0000_0000;
        case (region_s)
            REGION_RAM: begin
                dout_s = ram_r[ram_idx_s];
            end
            REGION_MMIO: begin
                case (mmio_off_s)
                    MMIO_CNT_LO:  dout_s = cnt_r[31:0];
                    MMIO_CNT_HI:  dout_s = snap_r;
                    MMIO_TX_DATA: dout_s = 32'h0000_0000;
                    MMIO_TX_STAT: dout_s = tx_stat_s;
                    default:      dout_s = 32'h0000_0000;
                endcase
            end
            default: begin
                dout_s = 32'h0000_0000;
            end
        endcase
    end

    // Byte-lane RAM write; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (lanes_s[lane]) begin
                    ram_r[ram_idx_s][lane*8 +: 8] <= wdata_s[lane*8 +: 8];
                end
            end
        end
    end

    // Free-running 64-bit cycle counter and its high-word snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= 64'h0;
            snap_r <= 32'h0;
        end else begin
            cnt_r <= cnt_r + 64'h1;
            if (snap_take_s) begin
                snap_r <= cnt_r[63:32];
            end
        end
    end

    // Sticky access error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err_r <= 1'b0;
        end else if (access_err_s) begin
            mem_err_r <= 1'b1;
        end
    end

    assign tx_pop_s = !tx_empty_s && tx_ready;

    data_mem_sys_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .W     (8)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_s),
        .din   (MEM_mem_din[7:0]),
        .pop   (tx_pop_s),
        .dout  (tx_data),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s),
        .ovf   (tx_ovf_s)
    );

    assign DM_mem_dout = dout_s;
    assign tx_valid    = !tx_empty_s;
    assign mem_err     = mem_err_r;

endmodule

// File: tb/tb_data_mem_sys.sv
// Self-checking bench for data_mem_sys: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the memory map,
// counter, sticky error and TX byte queue.
module tb_data_mem_sys;
    import data_mem_sys_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [3:0]  cmd;
    logic [31:0] din;
    logic [31:0] dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_err;

    int checks_cnt;
    int errors_cnt;
    bit chk_en;

    // Behavioural model state.
    bit [31:0] m_ram [int];
    bit [63:0] m_cnt;
    bit [31:0] m_snap;
    bit        m_err;
    bit        m_ovf;
    bit [7:0]  m_q [$];

    // Last sampled DUT outputs.
    logic [31:0] obs_dout;
    logic        obs_valid;
    logic [7:0]  obs_tx;
    logic        obs_err;

    data_mem_sys dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_mem_addr (addr),
        .MEM_mem_cmd  (cmd),
        .MEM_mem_din  (din),
        .DM_mem_dout  (dout),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .mem_err      (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_read(input bit [31:0] a);
        bit [31:0] r;
        int        sz;
        r  = 32'h0;
        sz = m_q.size();
        if ((a >> 4) == 32'h0FFF_F000) begin
            case (a[3:2])
                2'd0:    r = m_cnt[31:0];
                2'd1:    r = m_snap;
                2'd2:    r = 32'h0;
                default: r = (sz << 4) | (m_ovf ? 32'h8 : 32'h0)
                             | ((sz == 0) ? 32'h2 : 32'h0) | ((sz == 8) ? 32'h1 : 32'h0);
            endcase
        end else if (a < 32'd4096) begin
            r = m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'h0;
        end else begin
            r = 32'h0;
        end
        return r;
    endfunction

    task automatic model_edge(input bit [3:0] c, input bit [31:0] a, input bit [31:0] d,
                              input bit rdy, input bit r);
        bit        ld, st, mis, mmio, ram, pop, push;
        int        sz, wi;
        bit [31:0] w;
        if (r) begin
            m_err = 1'b0; m_ovf = 1'b0; m_cnt = 64'h0; m_snap = 32'h0;
            m_q.delete();
            return;
        end
        ld   = (c >= 4'd1) && (c <= 4'd5);
        st   = (c >= 4'd6) && (c <= 4'd8);
        mis  = (((c == 4'd2) || (c == 4'd5) || (c == 4'd7)) && a[0])
            || (((c == 4'd3) || (c == 4'd8)) && (a[1:0] != 2'b00));
        mmio = ((a >> 4) == 32'h0FFF_F000);
        ram  = !mmio && (a < 32'd4096);
        if ((ld || st) && (mis || (!mmio && !ram))) m_err = 1'b1;
        if (ld && mmio && (a[3:2] == 2'd0)) m_snap = m_cnt[63:32];
        if (st && !mis && ram) begin
            wi = int'(a >> 2);
            w  = m_ram.exists(wi) ? m_ram[wi] : 32'h0;
            case (c)
                4'd6:    w[8*a[1:0] +: 8]  = d[7:0];
                4'd7:    w[8*a[1:0] +: 16] = d[15:0];
                default: w = d;
            endcase
            m_ram[wi] = w;
        end
        sz   = m_q.size();
        pop  = (sz != 0) && rdy;
        push = st && !mis && mmio && (a[3:2] == 2'd2);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if ((sz < 8) || pop) m_q.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        m_cnt = m_cnt + 64'h1;
    endtask

    // One bus cycle: drive at negedge, sample and compare, then advance the model at posedge.
    task automatic step(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic r);
        @(negedge clk);
        rst = r; cmd = c; addr = a; din = d; tx_ready = rdy;
        #1;
        obs_dout = dout; obs_valid = tx_valid; obs_tx = tx_data; obs_err = mem_err;
        if (chk_en) begin
            check_eq("dout", obs_dout, model_read(a));
            check_eq("tx_valid", {31'b0, obs_valid}, {31'b0, (m_q.size() != 0)});
            if (m_q.size() != 0) check_eq("tx_data", {24'b0, obs_tx}, {24'b0, m_q[0]});
            check_eq("mem_err", {31'b0, obs_err}, {31'b0, m_err});
        end
        @(posedge clk);
        model_edge(c, a, d, rdy, r);
    endtask

    task automatic do_reset();
        step(4'(MEM_NONE), 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        bit [3:0]  rc;
        bit [31:0] ra, rd, rr;
        int        wi;
        checks_cnt = 0; errors_cnt = 0; chk_en = 1'b0;
        rst = 1'b1; cmd = 4'h0; addr = 32'h0; din = 32'h0; tx_ready = 1'b0;
        do_reset();
        do_reset();
        chk_en = 1'b1;
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_eq("rst_mem_err", {31'b0, mem_err}, 32'h0);

        // Preload the RAM words the rest of the bench reads.
        for (int i = 0; i < 32; i++) step(4'(MEM_SW), 32'(i * 4), $urandom, 1'b0, 1'b0);
        for (int i = 1020; i < 1024; i++) step(4'(MEM_SW), 32'(i * 4), $urandom, 1'b0, 1'b0);
        step(4'(MEM_SW), 32'h200, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Byte/half/word lane merging.
        step(4'(MEM_SW), 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(4'(MEM_SB), 32'h101, 32'h0000_0055, 1'b0, 1'b0);
        step(4'(MEM_SH), 32'h102, 32'h0000_1234, 1'b0, 1'b0);
        step(4'(MEM_LW), 32'h100, 32'h0, 1'b0, 1'b0);
        check_eq("t1_merge", obs_dout, 32'h1234_55EF);

        // Misaligned stores: no write, sticky error.
        step(4'(MEM_SH), 32'h201, 32'h1111_1111, 1'b0, 1'b0);
        step(4'(MEM_SW), 32'h202, 32'h2222_2222, 1'b0, 1'b0);
        step(4'(MEM_LW), 32'h200, 32'h0, 1'b0, 1'b0);
        check_eq("t2_unchanged", obs_dout, 32'hCAFE_F00D);
        check_eq("t2_err", {31'b0, obs_err}, 32'h1);
        for (int i = 0; i < 5; i++) step(4'(MEM_LW), 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("t2_err_sticky", {31'b0, obs_err}, 32'h1);
        do_reset();
        step(4'(MEM_NONE), 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("t2_err_cleared", {31'b0, obs_err}, 32'h0);

        // Counter and coherent high-word snapshot.
        do_reset();
        for (int i = 0; i < 100; i++) step(4'(MEM_NONE), 32'h0, 32'h0, 1'b0, 1'b0);
        step(4'(MEM_LW), 32'hFFFF_0000, 32'h0, 1'b0, 1'b0);
        check_eq("t3_lo", obs_dout, 32'd100);
        step(4'(MEM_LW), 32'hFFFF_0004, 32'h0, 1'b0, 1'b0);
        check_eq("t3_hi", obs_dout, 32'h0);
        #1;
        force dut.cnt_r = 64'h0000_0000_FFFF_FFFF;
        m_cnt = 64'h0000_0000_FFFF_FFFF;
        step(4'(MEM_LW), 32'hFFFF_0000, 32'h0, 1'b0, 1'b0);
        check_eq("t3_lo_max", obs_dout, 32'hFFFF_FFFF);
        #1;
        force dut.cnt_r = 64'h0000_0007_0000_0000;
        m_cnt = 64'h0000_0007_0000_0000;
        step(4'(MEM_LW), 32'hFFFF_0004, 32'h0, 1'b0, 1'b0);
        check_eq("t3_hi_snap", obs_dout, 32'h0);
        #1;
        release dut.cnt_r;
        do_reset();

        // Overflow on the ninth push, then ordered drain.
        for (int i = 0; i < 9; i++) step(4'(MEM_SB), 32'hFFFF_0008, 32'(8'h41 + i), 1'b0, 1'b0);
        step(4'(MEM_LW), 32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
        check_eq("t4_stat", obs_dout, 32'h0000_0089);
        for (int i = 0; i < 8; i++) begin
            step(4'(MEM_NONE), 32'h0, 32'h0, 1'b1, 1'b0);
            check_eq("t4_drain", {24'b0, obs_tx}, 32'(8'h41 + i));
        end
        step(4'(MEM_NONE), 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("t4_valid_low", {31'b0, obs_valid}, 32'h0);

        // Push and pop together while full.
        do_reset();
        for (int i = 0; i < 8; i++) step(4'(MEM_SB), 32'hFFFF_0008, 32'(8'h60 + i), 1'b0, 1'b0);
        step(4'(MEM_SB), 32'hFFFF_0008, 32'h0000_005A, 1'b1, 1'b0);
        step(4'(MEM_LW), 32'hFFFF_000C, 32'h0, 1'b0, 1'b0);
        check_eq("t5_stat", obs_dout, 32'h0000_0081);
        for (int i = 0; i < 7; i++) step(4'(MEM_NONE), 32'h0, 32'h0, 1'b1, 1'b0);
        step(4'(MEM_NONE), 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("t5_last", {24'b0, obs_tx}, 32'h0000_005A);

        // Unmapped load and reset mid-drain.
        step(4'(MEM_LW), 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        check_eq("t6_unmapped", obs_dout, 32'h0);
        step(4'(MEM_NONE), 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("t6_err", {31'b0, obs_err}, 32'h1);
        for (int i = 0; i < 3; i++) step(4'(MEM_SB), 32'hFFFF_0008, 32'(8'h70 + i), 1'b0, 1'b0);
        step(4'(MEM_NONE), 32'h0, 32'h0, 1'b1, 1'b0);
        step(4'(MEM_NONE), 32'h0, 32'h0, 1'b1, 1'b1);
        step(4'(MEM_NONE), 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("t6_valid_rst", {31'b0, obs_valid}, 32'h0);
        step(4'(MEM_LW), 32'h0000_0FFC, 32'h0, 1'b0, 1'b0);
        check_eq("t6_ram_kept", obs_dout, m_ram[1023]);

        // Randomized traffic over the pool, MMIO window and unmapped space.
        for (int n = 0; n < 600; n++) begin
            rc = 4'($urandom_range(0, 9));
            rd = $urandom;
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    wi = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 31))
                                                     : int'($urandom_range(1020, 1023));
                    ra = 32'(wi * 4) + 32'($urandom_range(0, 3));
                end
                3, 4:    ra = 32'hFFFF_0000 + 32'($urandom_range(0, 15));
                default: begin
                    rr = $urandom;
                    ra = ($urandom_range(0, 1) != 0) ? (32'h0000_1000 + 32'($urandom_range(0, 3)))
                                                     : (32'h8000_0000 | rr);
                end
            endcase
            if ($urandom_range(0, 99) == 0) step(4'(MEM_NONE), 32'h0, 32'h0, 1'($urandom_range(0, 1)), 1'b1);
            else step(rc, ra, rd, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
